// File: rtl/pio_in_poll_ctrl.sv
// Polls the 8-bit input PIO at a fixed rate, detects bit changes and queues
// change events (value, change mask, poll index) in a small FIFO.
//
//   state     | meaning
//   ST_IDLE   | waiting for a divider tick, PIO address parked at 1
//   ST_ISSUE  | PIO address 0 for one cycle, PIO registers its data
//   ST_SAMPLE | PIO read data valid, capture and compare
module pio_in_poll_ctrl #(
  parameter int POLL_DIV   = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  output logic [7:0]  cur_value,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_data,
  output logic [7:0]  evt_mask,
  output logic [15:0] evt_time,
  output logic        irq,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ISSUE  = 2'd1;
  localparam logic [1:0]  ST_SAMPLE = 2'd2;
  localparam int          AW        = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] DIV_LOAD  = 16'(POLL_DIV - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  logic [1:0]  state;
  logic [15:0] div_cnt;
  logic [15:0] poll_idx;
  logic        primed;
  logic        tick;
  logic        capture;
  logic [7:0]  sample_val;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        fifo_full;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [31:0] mem [FIFO_DEPTH];
  logic        unused_rd_hi;

  assign unused_rd_hi = ^pio_readdata[31:8];
  assign sample_val   = pio_readdata[7:0];
  assign tick         = enable && (div_cnt == 16'd0);
  assign capture      = (state == ST_SAMPLE);
  assign pio_address  = (state == ST_ISSUE) ? 2'd0 : 2'd1;

  // Divider free-runs while enabled so the poll period stays exactly POLL_DIV.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= DIV_LOAD;
    end else if (!enable || div_cnt == 16'd0) begin
      div_cnt <= DIV_LOAD;
    end else begin
      div_cnt <= div_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (tick) state <= ST_ISSUE;
        ST_ISSUE:  state <= ST_SAMPLE;
        ST_SAMPLE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_value <= 8'd0;
      primed    <= 1'b0;
      poll_idx  <= 16'd0;
    end else if (capture) begin
      cur_value <= sample_val;
      primed    <= 1'b1;
      poll_idx  <= poll_idx + 16'd1;
    end
  end

  assign push_req  = capture && primed && (sample_val != cur_value);
  assign evt_valid = (wr_ptr != rd_ptr);
  assign pop       = evt_valid && evt_ready;
  assign fifo_full = ((wr_ptr - rd_ptr) == DEPTH_CNT);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push_req && (!fifo_full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 32'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= {sample_val, sample_val ^ cur_value, poll_idx};
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign {evt_data, evt_mask, evt_time} = mem[rd_ptr[AW-1:0]];
  assign irq = evt_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push_req && !push_ok) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pio_in_poll_ctrl.sv
// Directed bench for pio_in_poll_ctrl with a registered, latency-1 PIO model.
module tb_pio_in_poll_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        evt_ready = 1'b0;
  logic        clr_overflow = 1'b0;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata = 32'd0;
  logic [7:0]  in_port = 8'h5A;
  logic [7:0]  cur_value, evt_data, evt_mask;
  logic [15:0] evt_time;
  logic        evt_valid, irq, overflow;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int issue_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Non-data addresses return inverted data so a mistimed capture is visible.
  always @(posedge clk)
    pio_readdata <= (pio_address == 2'd0) ? {24'h0, in_port} : {24'hFFFFFF, ~in_port};
  always @(negedge clk) if (reset_n && pio_address == 2'd0) issue_cnt <= issue_cnt + 1;

  pio_in_poll_ctrl #(.POLL_DIV(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(pio_address), .pio_readdata(pio_readdata),
    .cur_value(cur_value), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .evt_mask(evt_mask), .evt_time(evt_time),
    .irq(irq), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_issue(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pio_address == 2'd0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  // Sets the input, waits for the next ISSUE, returns in the cycle after SAMPLE.
  task automatic poll_to(input logic [7:0] v, output int c);
    in_port = v;
    wait_issue(c);
    @(negedge clk);
    chk("addr_in_sample", 32'(pio_address), 1);
    @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d, input logic [7:0] m,
                            input logic [15:0] t);
    chk({tag, "_valid"}, 32'(evt_valid), 1);
    chk({tag, "_irq"}, 32'(irq), 1);
    chk({tag, "_data"}, 32'(evt_data), 32'(d));
    chk({tag, "_mask"}, 32'(evt_mask), 32'(m));
    chk({tag, "_time"}, 32'(evt_time), 32'(t));
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c, cprev, en_cyc, n0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(pio_address), 1);
    chk("rst_cur", 32'(cur_value), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(evt_data), 0);
    chk("rst_mask", 32'(evt_mask), 0);
    chk("rst_time", 32'(evt_time), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Baseline poll: first sample never makes an event.
    enable = 1'b1;
    en_cyc = cyc;
    wait_issue(c);
    chk("first_issue_gap", 32'(c - en_cyc), 8);
    @(negedge clk);
    @(negedge clk);
    chk("base_cur", 32'(cur_value), 'h5A);
    chk("base_valid", 32'(evt_valid), 0);
    cprev = c;

    // Single-bit change.
    in_port = 8'h5B;
    wait_issue(c);
    chk("poll_spacing", 32'(c - cprev), 8);
    cprev = c;
    @(negedge clk);
    chk("valid_in_sample", 32'(evt_valid), 0);
    @(negedge clk);
    chk("chg_cur", 32'(cur_value), 'h5B);
    pop_expect("chg", 8'h5B, 8'h01, 16'd1);
    chk("chg_valid_after_pop", 32'(evt_valid), 0);

    // Overflow: polls 2..6 change every time, only four fit.
    for (int k = 0; k < 5; k++) begin
      poll_to((k % 2 == 0) ? 8'hA4 : 8'h5B, c);
      chk("ovf_spacing", 32'(c - cprev), 8);
      cprev = c;
      if (k == 3) chk("ovf_before_drop", 32'(overflow), 0);
      if (k == 4) chk("ovf_after_drop", 32'(overflow), 1);
    end
    // Poll 7 drops too, with a clear requested in the very same cycle.
    in_port = 8'h5B;
    wait_issue(c);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_set_beats_clr", 32'(overflow), 1);
    chk("ovf_cur_last", 32'(cur_value), 'h5B);
    chk("ovf_head_stable", 32'(evt_time), 2);
    pop_expect("ovf_e0", 8'hA4, 8'hFF, 16'd2);
    pop_expect("ovf_e1", 8'h5B, 8'hFF, 16'd3);
    pop_expect("ovf_e2", 8'hA4, 8'hFF, 16'd4);
    pop_expect("ovf_e3", 8'h5B, 8'hFF, 16'd5);
    chk("ovf_no_fifth", 32'(evt_valid), 0);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // Fill with polls 8..11, then push and pop together on poll 12.
    poll_to(8'hA4, c);
    poll_to(8'h5B, c);
    poll_to(8'hA4, c);
    poll_to(8'h5B, c);
    chk("full_ovf", 32'(overflow), 0);
    chk("full_head", 32'(evt_time), 8);
    in_port = 8'hA4;
    wait_issue(c);
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    chk("pp_ovf", 32'(overflow), 0);
    pop_expect("pp_e0", 8'h5B, 8'hFF, 16'd9);
    pop_expect("pp_e1", 8'hA4, 8'hFF, 16'd10);
    pop_expect("pp_e2", 8'h5B, 8'hFF, 16'd11);
    pop_expect("pp_e3", 8'hA4, 8'hFF, 16'd12);
    chk("pp_empty", 32'(evt_valid), 0);

    // Drop enable during ISSUE: poll 13 still completes, nothing follows.
    in_port = 8'h5B;
    wait_issue(c);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dis_cur", 32'(cur_value), 'h5B);
    chk("dis_valid", 32'(evt_valid), 1);
    chk("dis_data", 32'(evt_data), 'h5B);
    chk("dis_time", 32'(evt_time), 13);
    n0 = issue_cnt;
    repeat (30) @(negedge clk);
    chk("dis_no_issue", 32'(issue_cnt), 32'(n0));

    // Reset during SAMPLE with an event still queued.
    in_port = 8'hC3;
    enable = 1'b1;
    wait_issue(c);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mrst_addr", 32'(pio_address), 1);
    chk("mrst_cur", 32'(cur_value), 0);
    chk("mrst_valid", 32'(evt_valid), 0);
    chk("mrst_irq", 32'(irq), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    chk("mrst_data", 32'(evt_data), 0);
    chk("mrst_mask", 32'(evt_mask), 0);
    chk("mrst_time", 32'(evt_time), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_issue(c);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_rebase_cur", 32'(cur_value), 'hC3);
    chk("mrst_rebase_valid", 32'(evt_valid), 0);

    // Timestamp wrap: jump the poll index near the top while idle.
    enable = 1'b0;
    @(negedge clk);
    force dut.poll_idx = 16'hFFFE;
    @(negedge clk);
    release dut.poll_idx;
    @(negedge clk);
    enable = 1'b1;
    poll_to(8'h3C, c);
    cprev = c;
    pop_expect("wrap_fffe", 8'h3C, 8'hFF, 16'hFFFE);
    poll_to(8'hC3, c);
    chk("wrap_spacing0", 32'(c - cprev), 8);
    cprev = c;
    pop_expect("wrap_ffff", 8'hC3, 8'hFF, 16'hFFFF);
    poll_to(8'h3C, c);
    chk("wrap_spacing1", 32'(c - cprev), 8);
    cprev = c;
    pop_expect("wrap_0000", 8'h3C, 8'hFF, 16'h0000);
    poll_to(8'hC3, c);
    chk("wrap_spacing2", 32'(c - cprev), 8);
    pop_expect("wrap_0001", 8'hC3, 8'hFF, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
